// File: rtl/seq_sub_pkg.sv
// Shared constants, state encoding and counter sizing for the sequential carry-select subtractor.
// Optional overflow output is enabled by defining SEQ_SUB_OVF_EN.
package seq_sub_pkg;

    localparam int WIDTH_DEF  = 64;
    localparam int SLICE_DEF  = 8;
    localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_bits(NSLICE_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csel_sub_slice.sv
// Combinational carry-select subtract slice: two ripple borrow chains (borrow-in 0 and 1)
// computed in parallel, the incoming borrow picks the difference and borrow-out.
module csel_sub_slice
    import seq_sub_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bsel,
    output logic [SLICE-1:0] diff,
    output logic             bout
);

    logic [SLICE:0]   br0;
    logic [SLICE:0]   br1;
    logic [SLICE-1:0] d0;
    logic [SLICE-1:0] d1;

    assign br0[0] = 1'b0;
    assign br1[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign d0[gi]    = x[gi] ^ y[gi] ^ br0[gi];
            assign d1[gi]    = x[gi] ^ y[gi] ^ br1[gi];
            // Borrow is generated when x<y, propagated when x==y
            assign br0[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & br0[gi]);
            assign br1[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & br1[gi]);
        end
    endgenerate

    assign diff = bsel ? d1 : d0;
    assign bout = bsel ? br1[SLICE] : br0[SLICE];

endmodule

// File: rtl/seq_csel_sub_64.sv
// Multi-cycle subtractor diff = a - b - bin, one SLICE-bit carry-select step per cycle, LSB first.
// Defining SEQ_SUB_OVF_EN adds a signed-overflow output ovf.
module seq_csel_sub_64
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SEQ_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = cnt_bits(NSLICE);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              brw_q, brw_d;
    logic              zero_q, zero_d;
    logic [SLICE-1:0]  slc_diff;
    logic              slc_bout;
`ifdef SEQ_SUB_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
`endif

    csel_sub_slice #(.SLICE(SLICE)) u_slice (
        .x    (a_q[SLICE-1:0]),
        .y    (b_q[SLICE-1:0]),
        .bsel (brw_q),
        .diff (slc_diff),
        .bout (slc_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        zero_d  = zero_q;
`ifdef SEQ_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SEQ_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d   = a_q >> SLICE;
                b_d   = b_q >> SLICE;
                res_d = {slc_diff, res_q[WIDTH-1:SLICE]};
                brw_d = slc_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NSLICE - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Latch the flag so it keeps holding after the result is consumed
                zero_d = ~|res_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            zero_q  <= zero_d;
`ifdef SEQ_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign bout      = brw_q;
    assign zero      = (state_q == DONE) ? ~|res_q : zero_q;
`ifdef SEQ_SUB_OVF_EN
    assign ovf       = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_seq_csel_sub_64.sv
// Self-checking bench for seq_csel_sub_64: directed table, random ops against an arithmetic model,
// backpressure and mid-operation reset sequences.
module tb_seq_csel_sub_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
`ifdef SEQ_SUB_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    seq_csel_sub_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef SEQ_SUB_OVF_EN
        .ovf       (ovf),
`endif
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Reference: wide unsigned and signed arithmetic, no bit-level borrow logic
    function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                                  output logic [63:0] md, output logic mbo, output logic mz,
                                  output logic mo);
        logic [64:0]        full;
        logic signed [65:0] s;
        full = {1'b0, ma} - {1'b0, mb} - 65'(mbin);
        md   = full[63:0];
        mbo  = full[64];
        mz   = (md == 64'd0);
        s    = $signed({ma[63], ma[63], ma}) - $signed({mb[63], mb[63], mb}) - $signed({65'd0, mbin});
        mo   = (s != $signed({md[63], md[63], md}));
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 30 && !in_ready; i++) @(negedge clk);
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic launch(input logic [63:0] va, input logic [63:0] vb, input logic vbin);
        wait_ready();
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] ed, input logic ebo,
                                input logic ez, input logic eo);
        check({name, "_diff"}, diff, ed);
        check({name, "_bout"}, bout, ebo);
        check({name, "_zero"}, zero, ez);
`ifdef SEQ_SUB_OVF_EN
        check({name, "_ovf"}, ovf, eo);
`endif
        $display("op %s a=%h b=%h bin=%0d diff=%h bout=%0d zero=%0d ovf_exp=%0d",
                 name, a, b, bin, diff, bout, zero, eo);
    endtask

    task automatic handshake(input string name, input logic [63:0] ed);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({name, "_ov_drop"}, out_valid, 0);
        check({name, "_ir_rise"}, in_ready, 1);
        check({name, "_diff_hold"}, diff, ed);
    endtask

    task automatic run_check(input string name, input logic [63:0] va, input logic [63:0] vb,
                             input logic vbin, input logic [63:0] ed, input logic ebo,
                             input logic ez, input logic eo);
        int lat;
        launch(va, vb, vbin);
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), 64'd8);
        check_result(name, ed, ebo, ez, eo);
        handshake(name, ed);
    endtask

    initial begin
        logic [63:0] md;
        logic        mbo, mz, mo;
        logic [63:0] ra, rb, held;
        logic        rbin;
        int          lat;

        vt[0] = '{"basic",  64'h10, 64'h01, 1'b0, 64'h0F, 1'b0, 1'b0, 1'b0};
        vt[1] = '{"under1", 64'h0,  64'h1,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{"under2", 64'h0,  64'h0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[3] = '{"equal",  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0,
                  64'h0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{"ripple", 64'h0100_0000_0000_0000, 64'h1, 1'b0,
                  64'h00FF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vt[5] = '{"ovf1",   64'h8000_0000_0000_0000, 64'h1, 1'b0,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        vt[6] = '{"ovf0",   64'h5, 64'h3, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_zero", zero, 0);
`ifdef SEQ_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif

        for (int i = 0; i < 7; i++) begin
            run_check(vt[i].name, vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bo, vt[i].z, vt[i].o);
        end

        for (int i = 0; i < 20; i++) begin
            ra   = {$urandom, $urandom};
            rb   = (i % 4 == 0) ? ra : {$urandom, $urandom};
            if (i % 5 == 1) rb[63:8] = ra[63:8];
            rbin = 1'($urandom_range(0, 1));
            model(ra, rb, rbin, md, mbo, mz, mo);
            run_check($sformatf("rand%0d", i), ra, rb, rbin, md, mbo, mz, mo);
        end

        // Backpressure: result held in DONE while new operands wait on in_valid
        ra = 64'hDEAD_BEEF_0000_0001;
        rb = 64'h0000_0000_0000_0002;
        model(ra, rb, 1'b0, md, mbo, mz, mo);
        held = md;
        launch(ra, rb, 1'b0);
        wait_done(lat);
        check("bp_latency", 64'(lat), 64'd8);
        check_result("bp_first", md, mbo, mz, mo);
        a        = 64'h0000_0000_0000_0100;
        b        = 64'h0000_0000_0000_0001;
        bin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ov_held", out_valid, 1);
            check("bp_ir_low", in_ready, 0);
            check("bp_diff_held", diff, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_ov_drop", out_valid, 0);
        check("bp_ir_rise", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(lat);
        check("bp2_latency", 64'(lat), 64'd8);
        model(64'h100, 64'h1, 1'b1, md, mbo, mz, mo);
        check_result("bp_second", md, mbo, mz, mo);
        handshake("bp_second", md);

        // Reset in the middle of RUN discards the operation
        launch(64'hFFFF_0000_FFFF_0000, 64'h1111_2222_3333_4444, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_bout", bout, 0);
        check("mid_rst_zero", zero, 0);
        model(64'h0000_0001_0000_0000, 64'h1, 1'b0, md, mbo, mz, mo);
        run_check("post_rst", 64'h0000_0001_0000_0000, 64'h1, 1'b0, md, mbo, mz, mo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
